// File: rtl/stft_frame_reader_pkg.sv
// stft_pkg: shared constants for the STFT frame reader.
//   - default sample width, frame length, hop and buffer depth
//   - FSM state encodings (ST_IDLE, ST_STREAM)
//   - clog2 helper used to size pointers and counters
// No ports; imported by the interface, the sample bank and the top.
package stft_pkg;

  localparam int WL_DEF        = 10;
  localparam int FRAME_LEN_DEF = 16;
  localparam int HOP_DEF       = 8;
  localparam int DEPTH_DEF     = 32;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is reported as 1 so
  // that derived vectors are never zero width.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stft_frame_reader_if.sv
// stft_frame_reader_if: capture-side write strobe plus frame-stream handshake.
//   en, wdata         : sample write strobe and sample (driven by the capture side)
//   data, valid, ready: frame sample stream with valid/ready handshake
//   sof, last         : first / last sample of a frame, qualified by valid
//   ovf               : sticky "write dropped because buffer full"
//   frame_id          : frame counter, present only when FRAME_CNT_EN is defined
// Modports: master = the frame reader, slave = capture source + downstream sink.
interface stft_frame_reader_if
  import stft_pkg::*;
#(
  parameter int WL = WL_DEF
) ();

  logic          en;
  logic [WL-1:0] wdata;
  logic [WL-1:0] data;
  logic          valid;
  logic          ready;
  logic          sof;
  logic          last;
  logic          ovf;
`ifdef FRAME_CNT_EN
  logic [15:0]   frame_id;
`endif

  modport master (
    input  en, wdata, ready,
`ifdef FRAME_CNT_EN
    output frame_id,
`endif
    output data, valid, sof, last, ovf
  );

  modport slave (
    output en, wdata, ready,
`ifdef FRAME_CNT_EN
    input  frame_id,
`endif
    input  data, valid, sof, last, ovf
  );

endinterface

// File: rtl/stft_frame_reader_mem.sv
// frame_sample_mem: DEPTH x WL register bank holding captured samples.
//   clk   : clock, rising edge
//   we    : write strobe; the addressed word is loaded only when we is high
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
// Contents are not reset; the reader never reads a word it has not written.
module frame_sample_mem
  import stft_pkg::*;
#(
  parameter int WL    = WL_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WL-1:0]           wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WL-1:0]           rdata
);

  logic [WL-1:0] mem_r [DEPTH];

  // Enable-gated capture into the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read port.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/stft_frame_reader.sv
// stft_frame_reader: overlapped STFT framing over a circular sample buffer.
// Captured samples are stored in a DEPTH-entry bank; each complete frame of
// FRAME_LEN samples is streamed with valid/ready, then the frame start moves
// forward by HOP so consecutive frames overlap by FRAME_LEN-HOP samples.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : stft_frame_reader_if.master (write strobe, stream, sof/last, ovf)
// Optional build macro FRAME_CNT_EN adds bus.frame_id, a 16-bit frame counter
// that steps after each frame's last handshake.
module stft_frame_reader
  import stft_pkg::*;
#(
  parameter int WL        = WL_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int HOP       = HOP_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  stft_frame_reader_if.master bus
);

  localparam int AW = clog2(DEPTH);
  localparam int IW = clog2(FRAME_LEN);

  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] HOP_A    = AW'(HOP);
  localparam logic [AW:0]   ONE_AV   = (AW+1)'(1);
  localparam logic [AW:0]   HOP_AV   = (AW+1)'(HOP);
  localparam logic [AW:0]   DEPTH_AV = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FL_AV    = (AW+1)'(FRAME_LEN);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  logic [AW-1:0] wptr_r;
  logic [AW-1:0] base_r;
  logic [IW-1:0] idx_r;
  logic [AW:0]   avail_r;
  logic [0:0]    state_r;
  logic [WL-1:0] data_r;
  logic          valid_r;
  logic          sof_r;
  logic          last_r;
  logic          ovf_r;

  logic          wr_acc_s;
  logic          hs_s;
  logic          last_hs_s;
  logic [AW:0]   avail_nxt_s;
  logic [AW-1:0] raddr_s;
  logic [WL-1:0] rdata_s;

  // Write acceptance and handshake decode. Full is judged on the registered
  // avail, so the HOP release of a closing frame cannot free room this cycle.
  always_comb begin
    wr_acc_s  = bus.en && (avail_r != DEPTH_AV);
    hs_s      = valid_r && bus.ready;
    last_hs_s = hs_s && (idx_r == IDX_LAST);
  end

  // Read address: frame start when launching a frame, otherwise the sample
  // after the one being handed over.
  always_comb begin
    if (state_r == ST_IDLE) begin
      raddr_s = base_r;
    end else begin
      raddr_s = base_r + AW'(idx_r) + ONE_A;
    end
  end

  // Occupancy update: +1 per accepted write, -HOP when a frame completes.
  always_comb begin
    avail_nxt_s = avail_r;
    if (wr_acc_s) begin
      avail_nxt_s = avail_nxt_s + ONE_AV;
    end else begin
      avail_nxt_s = avail_nxt_s;
    end
    if (last_hs_s) begin
      avail_nxt_s = avail_nxt_s - HOP_AV;
    end else begin
      avail_nxt_s = avail_nxt_s;
    end
  end

  frame_sample_mem #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wptr_r),
    .wdata (bus.wdata),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Write pointer, frame base and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      base_r  <= '0;
      avail_r <= '0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + ONE_A;
      end
      if (last_hs_s) begin
        base_r <= base_r + HOP_A;
      end
      avail_r <= avail_nxt_s;
    end
  end

  // Sticky overflow: set by any write that finds the buffer full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (bus.en && !wr_acc_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Frame FSM and registered stream outputs. Leaving STREAM always passes
  // through IDLE, which produces the single bubble between frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      sof_r   <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (avail_r >= FL_AV) begin
            state_r <= ST_STREAM;
            idx_r   <= '0;
            data_r  <= rdata_s;
            valid_r <= 1'b1;
            sof_r   <= 1'b1;
            last_r  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (last_hs_s) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            valid_r <= 1'b0;
            sof_r   <= 1'b0;
            last_r  <= 1'b0;
          end else if (hs_s) begin
            idx_r   <= idx_r + IDX_ONE;
            data_r  <= rdata_s;
            sof_r   <= 1'b0;
            last_r  <= ((idx_r + IDX_ONE) == IDX_LAST);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          valid_r <= 1'b0;
          sof_r   <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_id_r;

  // Frame counter: steps after each completed frame, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_id_r <= 16'd0;
    end else if (last_hs_s) begin
      frame_id_r <= frame_id_r + 16'd1;
    end
  end

  assign bus.frame_id = frame_id_r;
`endif

  assign bus.data  = data_r;
  assign bus.valid = valid_r;
  assign bus.sof   = sof_r;
  assign bus.last  = last_r;
  assign bus.ovf   = ovf_r;

endmodule
